// File: rtl/clusterv_mgmt_regs_pkg.sv
// Shared definitions for the cluster management register block:
// register word offsets, CTRL/STATUS field positions, sequencer states.
package clusterv_mgmt_regs_pkg;

   // Word offsets decoded from t_adr[4:2]
   localparam logic [2:0] REG_CTRL    = 3'd0;
   localparam logic [2:0] REG_STATUS  = 3'd1;
   localparam logic [2:0] REG_DELAY   = 3'd2;
   localparam logic [2:0] REG_RSVD    = 3'd3;
   localparam logic [2:0] REG_RESVEC0 = 3'd4;

   // CTRL / STATUS field positions
   localparam int CTRL_RUN_BIT    = 0;
   localparam int CTRL_MASK_LSB   = 4;
   localparam int STATUS_BUSY_BIT = 8;

   // Release-delay counter width
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      SEQ_IDLE    = 2'd0,
      SEQ_WAIT    = 2'd1,
      SEQ_RELEASE = 2'd2,
      SEQ_RUN     = 2'd3
   } seq_state_e;

   // Merge write data into a 32-bit register honouring byte selects
   function automatic logic [31:0] apply_sel(input logic [31:0] cur,
                                             input logic [31:0] wdat,
                                             input logic [3:0]  sel);
      logic [31:0] r;
      r = cur;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) r[8*b +: 8] = wdat[8*b +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/clusterv_mgmt_regs_if.sv
// Wishbone classic register-port bundle between the management
// interconnect (master) and the register block (slave).
//
// Handshake: a request is pending while t_cyc & t_stb are high; the master
// holds t_adr/t_we/t_sel/t_dat_w stable until it sees t_ack. t_ack is a
// single-cycle pulse, read data on t_dat_r is valid only while t_ack is high,
// and a write takes effect on the same clock edge that raises t_ack.
interface clusterv_mgmt_regs_if #(
   parameter int ADR_WIDTH = 32,
   parameter int DAT_WIDTH = 32
);
   logic [ADR_WIDTH-1:0] t_adr;
   logic [DAT_WIDTH-1:0] t_dat_w;
   logic [DAT_WIDTH-1:0] t_dat_r;
   logic                 t_cyc;
   logic                 t_stb;
   logic                 t_we;
   logic [3:0]           t_sel;
   logic                 t_ack;
   logic                 t_err;

   modport master (
      output t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
      input  t_dat_r, t_ack, t_err
   );

   modport slave (
      input  t_adr, t_dat_w, t_cyc, t_stb, t_we, t_sel,
      output t_dat_r, t_ack, t_err
   );
endinterface

// File: rtl/clusterv_reset_seq.sv
// Core-reset release sequencer: lets harts out of reset one at a time in
// index order, with a programmable gap between consecutive releases.
module clusterv_reset_seq
   import clusterv_mgmt_regs_pkg::*;
#(
   parameter int N_HARTS = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               run,
   input  logic [N_HARTS-1:0] mask,
   input  logic [CNT_W-1:0]   delay,
   output logic [N_HARTS-1:0] core_reset,
   output logic               busy,
   output seq_state_e         state_dbg
);

   localparam int IDX_W = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HARTS - 1);

   seq_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [N_HARTS-1:0] core_reset_d;

   // State, counter, hart index and reset outputs register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q    <= SEQ_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         core_reset <= '1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         core_reset <= core_reset_d;
      end
   end

   // Next-state logic. A zero delay skips WAIT entirely so releases land on
   // consecutive edges; otherwise WAIT lasts exactly `delay` cycles and the
   // gap between release edges is delay + 1.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      core_reset_d = core_reset;
      if (!run) begin
         state_d      = SEQ_IDLE;
         core_reset_d = '1;
      end else begin
         case (state_q)
            SEQ_IDLE: begin
               core_reset_d = '1;
               idx_d        = '0;
               cnt_d        = delay;
               state_d      = (delay == '0) ? SEQ_RELEASE : SEQ_WAIT;
            end
            SEQ_WAIT: begin
               cnt_d = cnt_q - CNT_W'(1);
               if (cnt_q <= CNT_W'(1)) state_d = SEQ_RELEASE;
            end
            SEQ_RELEASE: begin
               if (mask[idx_q]) core_reset_d[idx_q] = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = SEQ_RUN;
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  cnt_d   = delay;
                  state_d = (delay == '0) ? SEQ_RELEASE : SEQ_WAIT;
               end
            end
            default: begin
               state_d = SEQ_RUN;
            end
         endcase
      end
   end

   assign busy      = (state_q == SEQ_WAIT);
   assign state_dbg = state_q;

endmodule

// File: rtl/clusterv_mgmt_regs.sv
// Management register block: Wishbone decode, CTRL/DELAY/RESVEC storage,
// constant hartid outputs, and the staggered core-reset sequencer.
module clusterv_mgmt_regs
   import clusterv_mgmt_regs_pkg::*;
#(
   parameter int          N_HARTS              = 4,
   parameter logic [31:0] DEFAULT_RESET_VECTOR = 32'h1000_0000,
   parameter logic [15:0] DEFAULT_DELAY        = 16'd16,
   parameter int          ADR_WIDTH            = 32,
   parameter int          DAT_WIDTH            = 32
) (
   input  logic                   clock,
   input  logic                   reset_n,
   clusterv_mgmt_regs_if.slave    wb,
   output logic [N_HARTS*32-1:0]  resvec,
   output logic [N_HARTS*32-1:0]  hartid,
   output logic [N_HARTS-1:0]     core_reset,
   output logic                   busy,
   output seq_state_e             seq_state
);

   // Which RESVEC slots exist for this hart count
   localparam logic [3:0] HART_PRESENT = 4'((5'd1 << N_HARTS) - 5'd1);

   logic                 req, commit, ack_q;
   logic [2:0]           word;
   logic                 resvec_hit;
   logic [DAT_WIDTH-1:0] rdata, dat_r_q;
   logic                 ctrl_run;
   logic [N_HARTS-1:0]   mask_q;
   logic [CNT_W-1:0]     delay_q;
   logic [31:0]          resvec_q [N_HARTS];
   logic                 unused_adr;

   assign req        = wb.t_cyc & wb.t_stb;
   assign commit     = req & ~ack_q;
   assign word       = wb.t_adr[4:2];
   assign resvec_hit = (word >= REG_RESVEC0) & HART_PRESENT[word[1:0]];
   assign unused_adr = ^{wb.t_adr[ADR_WIDTH-1:5], wb.t_adr[1:0]};

   // Read mux; unused bits, reserved words and absent harts read zero
   always_comb begin
      rdata = '0;
      case (word)
         REG_CTRL: begin
            rdata[CTRL_RUN_BIT]               = ctrl_run;
            rdata[CTRL_MASK_LSB +: N_HARTS]   = mask_q;
         end
         REG_STATUS: begin
            rdata[N_HARTS-1:0]     = core_reset;
            rdata[STATUS_BUSY_BIT] = busy;
         end
         REG_DELAY: rdata[CNT_W-1:0] = delay_q;
         default: begin
            if (resvec_hit) rdata = resvec_q[word[1:0]];
         end
      endcase
   end

   // Ack pulse, registered read data and register writes on the ack edge
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ack_q    <= 1'b0;
         dat_r_q  <= '0;
         ctrl_run <= 1'b0;
         mask_q   <= '0;
         delay_q  <= DEFAULT_DELAY;
         for (int h = 0; h < N_HARTS; h++) resvec_q[h] <= DEFAULT_RESET_VECTOR;
      end else begin
         ack_q   <= commit;
         dat_r_q <= (commit && !wb.t_we) ? rdata : '0;
         if (commit && wb.t_we) begin
            case (word)
               REG_CTRL: begin
                  if (wb.t_sel[0]) begin
                     ctrl_run <= wb.t_dat_w[CTRL_RUN_BIT];
                     mask_q   <= wb.t_dat_w[CTRL_MASK_LSB +: N_HARTS];
                  end
               end
               REG_DELAY: begin
                  if (wb.t_sel[0]) delay_q[7:0]  <= wb.t_dat_w[7:0];
                  if (wb.t_sel[1]) delay_q[15:8] <= wb.t_dat_w[15:8];
               end
               default: begin
                  if (resvec_hit)
                     resvec_q[word[1:0]] <= apply_sel(resvec_q[word[1:0]], wb.t_dat_w, wb.t_sel);
               end
            endcase
         end
      end
   end

   assign wb.t_ack   = ack_q;
   assign wb.t_dat_r = dat_r_q;
   assign wb.t_err   = 1'b0;

   for (genvar h = 0; h < N_HARTS; h++) begin : g_hart
      assign resvec[32*h +: 32] = resvec_q[h];
      assign hartid[32*h +: 32] = 32'(h);
   end

   clusterv_reset_seq #(
      .N_HARTS (N_HARTS)
   ) u_seq (
      .clock      (clock),
      .reset_n    (reset_n),
      .run        (ctrl_run),
      .mask       (mask_q),
      .delay      (delay_q),
      .core_reset (core_reset),
      .busy       (busy),
      .state_dbg  (seq_state)
   );

endmodule
